// File: rtl/mmr_pkg.sv
// rtl/mmr_pkg.sv - shared address map and state types for the mismatch collector
package mmr_pkg;

  localparam logic [1:0] MMR_ADDR_FLAGS = 2'd0;
  localparam logic [1:0] MMR_ADDR_CNT   = 2'd1;
  localparam logic [1:0] MMR_ADDR_FIRST = 2'd2;
  localparam logic [1:0] MMR_ADDR_CLR   = 2'd3;

  typedef enum logic {IDLE, PENDING} coll_state_t;

  // ACC_ACK means "access done, waiting for the requester to drop req_i"
  typedef enum logic {ACC_WAIT, ACC_ACK} acc_state_t;

endpackage

// File: rtl/mmr_mismatch_edge.sv
// rtl/mmr_mismatch_edge.sv - rising-edge detector for one mismatch source
module mmr_mismatch_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic mismatch_i,
  output logic ev_o
);

  logic r_prev;

  // remember last cycle's level so a held mismatch is reported only once
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_prev <= 1'b0;
    else       r_prev <= mismatch_i;
  end

  assign ev_o = mismatch_i & ~r_prev;

endmodule

// File: rtl/mmr_mismatch_collector.sv
// rtl/mmr_mismatch_collector.sv - SEU event collector with sticky flags, counter and first-source capture
module mmr_mismatch_collector
  import mmr_pkg::*;
#(
  parameter int NUM_SRC = 16,
  parameter int CNT_W   = 16,
  parameter int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_SRC-1:0] mismatch_i,
  input  logic               req_i,
  input  logic [1:0]         addr_i,
  output logic               ack_o,
  output logic [63:0]        rdata_o,
  output logic               irq_o
);

  // popcount of up to 64 events fits in 7 bits; one extra bit catches the saturation overflow
  localparam int PC_W  = 7;
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  function automatic logic [PC_W-1:0] popcount(input logic [NUM_SRC-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_SRC; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction

  function automatic logic [SRC_W-1:0] lowest_idx(input logic [NUM_SRC-1:0] v);
    logic [SRC_W-1:0] idx;
    idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) if (v[i]) idx = SRC_W'(i);
    return idx;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [PC_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > CNT_MAX) return {CNT_W{1'b1}};
    return s[CNT_W-1:0];
  endfunction

  logic [NUM_SRC-1:0] w_ev;
  logic               w_any_ev;
  logic [PC_W-1:0]    w_pc;
  logic [SRC_W-1:0]   w_low_idx;
  logic               w_action;
  logic               w_clear;
  logic [63:0]        w_rdata_sel;

  logic [NUM_SRC-1:0] r_flags;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_first_vld;
  logic [SRC_W-1:0]   r_first_idx;
  logic               r_ack;
  logic [63:0]        r_rdata;

  coll_state_t r_coll_state, w_coll_next;
  acc_state_t  r_acc_state, w_acc_next;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_edge
    mmr_mismatch_edge u_edge (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .mismatch_i (mismatch_i[g]),
      .ev_o       (w_ev[g])
    );
  end

  assign w_any_ev  = |w_ev;
  assign w_pc      = popcount(w_ev);
  assign w_low_idx = lowest_idx(w_ev);
  assign w_action  = (r_acc_state == ACC_WAIT) && req_i;
  assign w_clear   = w_action && (addr_i == MMR_ADDR_CLR);

  // collector state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_coll_state <= IDLE;
    else       r_coll_state <= w_coll_next;
  end

  // a new event always wins over a clear in the same cycle so it is never lost
  always_comb begin
    w_coll_next = r_coll_state;
    if (w_any_ev)     w_coll_next = PENDING;
    else if (w_clear) w_coll_next = IDLE;
  end

  // access state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_acc_state <= ACC_WAIT;
    else       r_acc_state <= w_acc_next;
  end

  // act once per request, then wait for req_i to fall before re-arming
  always_comb begin
    w_acc_next = r_acc_state;
    case (r_acc_state)
      ACC_WAIT: if (req_i)  w_acc_next = ACC_ACK;
      ACC_ACK:  if (!req_i) w_acc_next = ACC_WAIT;
      default:              w_acc_next = ACC_WAIT;
    endcase
  end

  // read mux sees the registered values, i.e. the state before this cycle's events
  always_comb begin
    w_rdata_sel = '0;
    case (addr_i)
      MMR_ADDR_FLAGS: w_rdata_sel = 64'(r_flags);
      MMR_ADDR_CNT:   w_rdata_sel = 64'(r_cnt);
      MMR_ADDR_FIRST: w_rdata_sel = {r_first_vld, 63'(r_first_idx)};
      default:        w_rdata_sel = '0;
    endcase
  end

  // sticky flags, saturating counter and first-source capture; a clear reloads from this cycle's events
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_flags     <= '0;
      r_cnt       <= '0;
      r_first_vld <= 1'b0;
      r_first_idx <= '0;
    end else if (w_clear) begin
      r_flags     <= w_ev;
      r_cnt       <= sat_add('0, w_pc);
      r_first_vld <= w_any_ev;
      r_first_idx <= w_low_idx;
    end else begin
      r_flags <= r_flags | w_ev;
      r_cnt   <= sat_add(r_cnt, w_pc);
      if (!r_first_vld && w_any_ev) begin
        r_first_vld <= 1'b1;
        r_first_idx <= w_low_idx;
      end
    end
  end

  // one-cycle acknowledge with read data captured in the action cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack <= w_action;
      if (w_action) r_rdata <= w_rdata_sel;
    end
  end

  assign ack_o   = r_ack;
  assign rdata_o = r_rdata;
  assign irq_o   = (r_coll_state == PENDING);

endmodule
